image_streamer: RTL and testbench

Frame source for the CNN pipeline's pixel input. It buffers up to two complete ImageWidth×ImageWidth frames written by a host or loader port, then streams each frame in raster order into the CNN top's pixel input (`in_valid`/`in_data`). It obeys the CNN's ready signal and a per-pixel pacing interval that matches the first convolution layer's cycles-per-pixel. Two banks are used in ping-pong, so loading the next frame overlaps streaming of the current one.

---
 rtl/image_streamer_pkg.sv | 18 +
 rtl/image_streamer_pixel_bank.sv | 23 ++
 rtl/image_streamer.sv | 181 ++++++++++++++++++
 tb/tb_image_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_streamer_pkg.sv
// Shared types and helpers for the image_streamer frame source.
package image_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    PACE
  } state_e;

  localparam int StallW = 16;

  function automatic int addr_w(input int image_width);
    int n;
    n = image_width * image_width;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_streamer_pixel_bank.sv
// One frame of pixel storage: synchronous write, asynchronous read.
module pixel_bank #(
  parameter int BitSize = 32,
  parameter int NumPix  = 64,
  parameter int AddrW   = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AddrW-1:0]   waddr,
  input  logic [BitSize-1:0] wdata,
  input  logic [AddrW-1:0]   raddr,
  output logic [BitSize-1:0] rdata
);

  logic [BitSize-1:0] mem_q [NumPix];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/image_streamer.sv
// Ping-pong frame buffer streaming raster pixels into the CNN input.
// Define IMAGE_STREAMER_STALL_CNT_EN to add the stall_count port.
module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int BitSize        = 32,
  parameter int ImageWidth     = 8,
  parameter int CyclesPerPixel = 2
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             wr_en,
  input  logic [addr_w(ImageWidth)-1:0]    wr_addr,
  input  logic [BitSize-1:0]               wr_data,
  input  logic                             wr_last,
  output logic                             wr_ready,
  input  logic                             in_ready,
  output logic                             out_valid,
  output logic [BitSize-1:0]               out_data,
  output logic                             out_last,
  output logic                             frame_done,
  output logic                             busy
`ifdef IMAGE_STREAMER_STALL_CNT_EN
  ,
  output logic [StallW-1:0]                stall_count
`endif
);

  localparam int NumPix = ImageWidth * ImageWidth;
  localparam int AW     = addr_w(ImageWidth);
  localparam int PW     = $clog2(CyclesPerPixel + 1);
  localparam logic [PW-1:0] PaceLast =
    PW'((CyclesPerPixel > 1) ? CyclesPerPixel - 2 : 0);
  localparam logic [AW-1:0] LastPix = AW'(NumPix - 1);

  state_e             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      pace_q, pace_d;
  logic [BitSize-1:0] out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               frame_done_q, frame_done_d;

  logic               wr_ok, xfer, load;
  logic [AW-1:0]      rd_addr;
  logic [BitSize-1:0] rdata [2];

  assign wr_ready   = !full_q[wr_bank_q];
  assign wr_ok      = wr_en && wr_ready;
  assign out_valid  = (state_q == PRESENT);
  assign xfer       = out_valid && in_ready;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = |full_q;

  // Without pacing the next pixel is fetched in the transfer cycle.
  assign rd_addr = (xfer && CyclesPerPixel == 1) ?
                   rd_ptr_q + 1'b1 : rd_ptr_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pixel_bank #(
      .BitSize(BitSize),
      .NumPix (NumPix),
      .AddrW  (AW)
    ) u_bank (
      .clk  (clk),
      .we   (wr_ok && (wr_bank_q == 1'(b))),
      .waddr(wr_addr),
      .wdata(wr_data),
      .raddr(rd_addr),
      .rdata(rdata[b])
    );
  end

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    rd_ptr_d     = rd_ptr_q;
    pace_d       = pace_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    if (wr_ok && wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end

    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (in_ready) begin
          pace_d = '0;
          if (rd_ptr_q == LastPix) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rd_ptr_d          = '0;
            frame_done_d      = 1'b1;
            state_d = (CyclesPerPixel > 1) ? PACE : IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (CyclesPerPixel > 1) state_d = PACE;
            else load = 1'b1;
          end
        end
      end
      PACE: begin
        if (pace_q == PaceLast) begin
          // rd_ptr back at 0 means the frame just ended.
          if (rd_ptr_q != '0) begin
            load    = 1'b1;
            state_d = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pace_d = pace_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_data_d = rdata[rd_bank_q];
      out_last_d = (rd_addr == LastPix);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      rd_ptr_q     <= '0;
      pace_q       <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      rd_ptr_q     <= rd_ptr_d;
      pace_q       <= pace_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef IMAGE_STREAMER_STALL_CNT_EN
  logic [StallW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !in_ready && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench: dut1 paces at 2 cycles/pixel, dut2 at 1.
module tb_image_streamer;

  logic        clk;
  logic        res1, res2;
  logic        wr_en, wr_last, in_ready;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  logic        wr_ready1, out_valid1, out_last1, frame_done1, busy1;
  logic        wr_ready2, out_valid2, out_last2, frame_done2, busy2;
  logic [31:0] out_data1, out_data2;
`ifdef IMAGE_STREAMER_STALL_CNT_EN
  logic [15:0] stall1, stall2;
`endif

  logic        sel;
  logic        o_valid, o_last, o_frame_done, o_wr_ready, o_busy;
  logic [31:0] o_data;

  assign o_valid      = sel ? out_valid2  : out_valid1;
  assign o_last       = sel ? out_last2   : out_last1;
  assign o_frame_done = sel ? frame_done2 : frame_done1;
  assign o_wr_ready   = sel ? wr_ready2   : wr_ready1;
  assign o_busy       = sel ? busy2       : busy1;
  assign o_data       = sel ? out_data2   : out_data1;

  int n_cmp = 0;
  int n_bad = 0;

  image_streamer #(
    .BitSize(32), .ImageWidth(8), .CyclesPerPixel(2)
  ) dut1 (
    .clk(clk), .res(res1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready1),
    .in_ready(in_ready), .out_valid(out_valid1),
    .out_data(out_data1), .out_last(out_last1),
    .frame_done(frame_done1), .busy(busy1)
`ifdef IMAGE_STREAMER_STALL_CNT_EN
    , .stall_count(stall1)
`endif
  );

  image_streamer #(
    .BitSize(32), .ImageWidth(8), .CyclesPerPixel(1)
  ) dut2 (
    .clk(clk), .res(res2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready2),
    .in_ready(in_ready), .out_valid(out_valid2),
    .out_data(out_data2), .out_last(out_last2),
    .frame_done(frame_done2), .busy(busy2)
`ifdef IMAGE_STREAMER_STALL_CNT_EN
    , .stall_count(stall2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset1();
    res1 = 1'b1;
    tick();
    res1 = 1'b0;
  endtask

  task automatic write_px(input int a, input int d, input bit last);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = 32'(d);
    wr_last = last;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < 64; i++) write_px(i, base + i, i == 63);
  endtask

  task automatic wait_px(input int val);
    bit found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (o_valid && o_data == 32'(val)) found = 1'b1;
      else tick();
    end
    chk("wait_px", 64'(found), 64'd1);
  endtask

  task automatic stream_frame(input int base, input int spacing,
                              input bit rdy_last);
    int idx = 0;
    int prev_c = 0;
    int last_c = 0;
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (o_frame_done) begin
        chk("fd_cycle", 64'(c), 64'(last_c + 1));
        chk("fd_wr_ready", 64'(o_wr_ready), 64'd1);
        done = 1'b1;
      end
      if (o_valid && in_ready && idx < 64) begin
        chk("beat_data", 64'(o_data), 64'(base + idx));
        chk("beat_last", 64'(o_last), 64'(idx == 63));
        if (idx > 0) chk("beat_gap", 64'(c - prev_c), 64'(spacing));
        if (idx == 63) begin
          chk("wr_ready_last", 64'(o_wr_ready), 64'(rdy_last));
          last_c = c;
        end
        prev_c = c;
        idx++;
      end
      tick();
    end
    chk("beats", 64'(idx), 64'd64);
    chk("fd_seen", 64'(done), 64'd1);
    chk("fd_pulse", 64'(o_frame_done), 64'd0);
  endtask

  initial begin
    res1 = 1'b1; res2 = 1'b1; sel = 1'b0;
    wr_en = 1'b0; wr_last = 1'b0; in_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    tick();
    tick();
    res1 = 1'b0;

    // reset values
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_fd", 64'(o_frame_done), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_wr_ready", 64'(o_wr_ready), 64'd1);
`ifdef IMAGE_STREAMER_STALL_CNT_EN
    chk("rst_stall", 64'(stall1), 64'd0);
`endif

    // single frame, paced at 2 cycles per pixel
    in_ready = 1'b1;
    load_frame(0);
    chk("lat_idle", 64'(o_valid), 64'd0);
    chk("busy_commit", 64'(o_busy), 64'd1);
    tick();
    chk("lat_valid", 64'(o_valid), 64'd1);
    stream_frame(0, 2, 1'b1);
    chk("busy_end", 64'(o_busy), 64'd0);

    // stall for 5 cycles on pixel 10
    reset1();
    load_frame(0);
    wait_px(10);
    in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_data", 64'(o_data), 64'd10);
    end
`ifdef IMAGE_STREAMER_STALL_CNT_EN
    chk("stall_count", 64'(stall1), 64'd5);
`endif
    in_ready = 1'b1;
    tick();
    chk("pace_gap", 64'(o_valid), 64'd0);
    tick();
    chk("px11_valid", 64'(o_valid), 64'd1);
    chk("px11_data", 64'(o_data), 64'd11);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        if (o_frame_done) seen = 1'b1;
        tick();
      end
      chk("stall_frame_done", 64'(seen), 64'd1);
    end

    // two frames queued; a write with both banks full is dropped
    reset1();
    in_ready = 1'b0;
    load_frame(0);
    chk("wr_ready_b", 64'(o_wr_ready), 64'd1);
    load_frame(100);
    chk("wr_ready_full", 64'(o_wr_ready), 64'd0);
    chk("busy_full", 64'(o_busy), 64'd1);
    write_px(0, 999, 1'b1);
    chk("wr_ready_drop", 64'(o_wr_ready), 64'd0);
    in_ready = 1'b1;
    stream_frame(0, 2, 1'b0);
    stream_frame(100, 2, 1'b1);
    chk("busy_ab", 64'(o_busy), 64'd0);

    // reset while pixel 20 is presented
    reset1();
    load_frame(0);
    wait_px(20);
    res1 = 1'b1;
    tick();
    res1 = 1'b0;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_wr_ready", 64'(o_wr_ready), 64'd1);
    load_frame(50);
    stream_frame(50, 2, 1'b1);

    // unpaced instance: 64 back-to-back beats
    res1 = 1'b1;
    res2 = 1'b0;
    sel  = 1'b1;
    load_frame(0);
    stream_frame(0, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
